// File: rtl/cnn_layer_accel_fas_vec_add_ctrl_if.sv
// cnn_layer_accel_fas_vec_add_ctrl_if: command, FIFO flag/enable and strobe bundle for the FAS vector-add controller
interface cnn_layer_accel_fas_vec_add_ctrl_if #(parameter int C_DPTH_W = 16);
  logic FAS_rdy_n, start;
  logic [2:0] mode_cfg;
  logic [C_DPTH_W-1:0] krnl1x1_dpth_end_cfg, pix_end_cfg;
  logic convMap_empty, partMap_empty, resdMap_empty, prevMap_empty, dwc_empty, out_fifo_full;
  logic convMap_rd_en, partMap_rd_en, resdMap_rd_en, prevMap_rd_en, dwc_rd_en;
  logic vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv;
  logic pipe_enable, out_fifo_wr_en, busy, process_cmpl, cfg_err;
  modport master (
    output FAS_rdy_n, start, mode_cfg, krnl1x1_dpth_end_cfg, pix_end_cfg,
           convMap_empty, partMap_empty, resdMap_empty, prevMap_empty, dwc_empty, out_fifo_full,
    input  convMap_rd_en, partMap_rd_en, resdMap_rd_en, prevMap_rd_en, dwc_rd_en,
           vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv,
           pipe_enable, out_fifo_wr_en, busy, process_cmpl, cfg_err
  );
  modport slave (
    input  FAS_rdy_n, start, mode_cfg, krnl1x1_dpth_end_cfg, pix_end_cfg,
           convMap_empty, partMap_empty, resdMap_empty, prevMap_empty, dwc_empty, out_fifo_full,
    output convMap_rd_en, partMap_rd_en, resdMap_rd_en, prevMap_rd_en, dwc_rd_en,
           vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv,
           pipe_enable, out_fifo_wr_en, busy, process_cmpl, cfg_err
  );
endinterface

// File: rtl/cnn_layer_accel_fas_vec_add_ctrl.sv
// cnn_layer_accel_fas_vec_add_ctrl: sequences depth x pixel vector-add beats, gated on source/sink FIFO readiness
module cnn_layer_accel_fas_vec_add_ctrl #(parameter int C_DPTH_W = 16) (
  input logic clk_FAS,
  input logic rst,
  cnn_layer_accel_fas_vec_add_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [2:0] mode;
  logic [C_DPTH_W-1:0] dpth_end, pix_end, dpth, pix;
  logic [4:0] req, emp;
  logic pe, wr_q, err_q;
  assign emp = {bus.convMap_empty, bus.partMap_empty, bus.resdMap_empty, bus.prevMap_empty, bus.dwc_empty};
  // source mask order: conv, part, resd, prev, dwc
  always_comb req = mode == 3'd0 ? 5'b11000 :
                    mode == 3'd1 ? 5'b10100 :
                    mode == 3'd2 ? 5'b11100 :
                    mode == 3'd3 ? 5'b00101 :
                    mode == 3'd4 ? 5'b00011 : 5'b00000;
  assign pe = state == RUN && !(|(req & emp)) && !bus.out_fifo_full;
  assign {bus.convMap_rd_en, bus.partMap_rd_en, bus.resdMap_rd_en, bus.prevMap_rd_en, bus.dwc_rd_en} = pe ? req : 5'b0;
  assign {bus.vector_add_pm, bus.vector_add_rm0, bus.vector_add_rm1, bus.vector_add_rm_conv, bus.vector_add_pv} =
    pe ? 5'b10000 >> mode : 5'b0;
  assign bus.pipe_enable = pe;
  assign bus.out_fifo_wr_en = wr_q;
  assign bus.cfg_err = err_q;
  assign bus.busy = state != IDLE;
  assign bus.process_cmpl = state == DONE;
  always_ff @(posedge clk_FAS)
    if (rst || bus.FAS_rdy_n) begin
      state <= IDLE;
      dpth <= '0;
      pix <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      if (rst) begin
        mode <= '0;
        dpth_end <= '0;
        pix_end <= '0;
      end
    end else begin
      wr_q <= pe;
      err_q <= state == IDLE && bus.start && bus.mode_cfg > 3'd4;
      if (state == IDLE && bus.start && bus.mode_cfg <= 3'd4) begin
        state <= RUN;
        mode <= bus.mode_cfg;
        dpth_end <= bus.krnl1x1_dpth_end_cfg;
        pix_end <= bus.pix_end_cfg;
        dpth <= '0;
        pix <= '0;
      end else if (state == DONE) state <= IDLE;
      else if (pe) begin
        dpth <= dpth == dpth_end ? '0 : dpth + 1'b1;
        if (dpth == dpth_end) begin
          pix <= pix + 1'b1;
          if (pix == pix_end) state <= DONE;
        end
      end
    end
endmodule

// File: tb/tb_cnn_layer_accel_fas_vec_add_ctrl.sv
// tb_cnn_layer_accel_fas_vec_add_ctrl: beat-count reference model feeding a scoreboard checked by a negedge monitor
module tb_cnn_layer_accel_fas_vec_add_ctrl;
  localparam int W = 16;
  logic clk_FAS = 1'b0, rst = 1'b1;
  logic start = 1'b0, rdy_n = 1'b0, full = 1'b0;
  logic [2:0] mode = '0;
  logic [W-1:0] dcfg = '0, pcfg = '0;
  logic [4:0] emp = '0;
  cnn_layer_accel_fas_vec_add_ctrl_if #(.C_DPTH_W(W)) bus();
  cnn_layer_accel_fas_vec_add_ctrl #(.C_DPTH_W(W)) dut (.clk_FAS(clk_FAS), .rst(rst), .bus(bus.slave));
  assign bus.start = start;
  assign bus.FAS_rdy_n = rdy_n;
  assign bus.mode_cfg = mode;
  assign bus.krnl1x1_dpth_end_cfg = dcfg;
  assign bus.pix_end_cfg = pcfg;
  assign {bus.convMap_empty, bus.partMap_empty, bus.resdMap_empty, bus.prevMap_empty, bus.dwc_empty} = emp;
  assign bus.out_fifo_full = full;
  always #5 clk_FAS = ~clk_FAS;

  typedef struct {int c; logic [4:0] rd; logic [4:0] st;} beat_t;
  beat_t beat_q[$];
  int cmpl_q[$], err_q[$];
  bit exp_wr[int];
  int cyc = 0, checks = 0, failures = 0, dut_beats = 0;
  int ms = 0, rem = 0, mmode = 0;
  bit exp_busy = 0, mon_en = 0;
  always @(posedge clk_FAS) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", n, cyc, a, e);
    end
  endtask

  function automatic logic [4:0] req_of(int m);
    case (m)
      0: return 5'b11000;
      1: return 5'b10100;
      2: return 5'b11100;
      3: return 5'b00101;
      default: return 5'b00011;
    endcase
  endfunction

  // Model: an operation is simply a number of beats still owed; a beat happens whenever all required sources have data and the sink has room.
  task automatic model_eval();
    logic [4:0] rq;
    bit beat;
    rq = req_of(mmode);
    exp_busy = ms != 0;
    if (ms == 2) cmpl_q.push_back(cyc);
    beat = ms == 1 && (rq & emp) == 0 && !full;
    if (beat) begin
      beat_q.push_back('{cyc, rq, 5'b10000 >> mmode});
      if (!rst && !rdy_n) exp_wr[cyc] = 1;
    end
    if (rst || rdy_n) ms = 0;
    else if (ms == 0 && start) begin
      if (mode < 5) begin
        ms = 1;
        mmode = int'(mode);
        rem = (int'(dcfg) + 1) * (int'(pcfg) + 1);
      end else err_q.push_back(cyc + 1);
    end else if (ms == 1 && beat) begin
      rem--;
      if (rem == 0) ms = 2;
    end else if (ms == 2) ms = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk_FAS);
    #1;
  endtask

  logic [4:0] m_rd, m_st;
  beat_t m_b;
  int m_c;
  always @(negedge clk_FAS) if (mon_en) begin
    m_rd = {bus.convMap_rd_en, bus.partMap_rd_en, bus.resdMap_rd_en, bus.prevMap_rd_en, bus.dwc_rd_en};
    m_st = {bus.vector_add_pm, bus.vector_add_rm0, bus.vector_add_rm1, bus.vector_add_rm_conv, bus.vector_add_pv};
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("wr_en", 32'(bus.out_fifo_wr_en), 32'(exp_wr.exists(cyc - 1)));
    if (bus.pipe_enable) begin
      dut_beats++;
      if (beat_q.size() == 0) chk("unexpected_beat", 32'(1), 32'(0));
      else begin
        m_b = beat_q.pop_front();
        chk("beat_cycle", cyc, m_b.c);
        chk("rd_en", 32'(m_rd), 32'(m_b.rd));
        chk("strobe", 32'(m_st), 32'(m_b.st));
      end
    end else begin
      chk("idle_rd_strobe", 32'({m_rd, m_st}), 32'(0));
      if (beat_q.size() != 0 && beat_q[0].c <= cyc) begin
        m_b = beat_q.pop_front();
        chk("missing_beat", 32'(0), 32'(1));
      end
    end
    if (bus.process_cmpl) begin
      if (cmpl_q.size() == 0) chk("unexpected_cmpl", 32'(1), 32'(0));
      else begin m_c = cmpl_q.pop_front(); chk("cmpl_cycle", cyc, m_c); end
    end else if (cmpl_q.size() != 0 && cmpl_q[0] <= cyc) begin
      m_c = cmpl_q.pop_front();
      chk("missing_cmpl", 32'(0), 32'(1));
    end
    if (bus.cfg_err) begin
      if (err_q.size() == 0) chk("unexpected_cfg_err", 32'(1), 32'(0));
      else begin m_c = err_q.pop_front(); chk("cfg_err_cycle", cyc, m_c); end
    end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
      m_c = err_q.pop_front();
      chk("missing_cfg_err", 32'(0), 32'(1));
    end
  end

  // pol: 0 all ready, 1 random flags + stray starts, 2 sink full every other cycle, 3 resd empty for 5 cycles after first beat
  task automatic run_op(int m, int d, int p, int pol, int exp_beats);
    mode = 3'(m); dcfg = W'(d); pcfg = W'(p);
    emp = '0; full = 1'b0; start = 1'b1; dut_beats = 0;
    tick();
    start = 1'b0;
    for (int n = 0; ms != 0; n++) begin
      if (n > 3000) begin chk("op_timeout", 32'(n), 32'(0)); break; end
      case (pol)
        1: begin
          emp = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
          full = $urandom_range(0, 3) == 0;
        end
        2: begin emp = '0; full = n[0]; end
        3: begin emp = (n >= 1 && n < 6) ? 5'b00100 : 5'b0; full = 1'b0; end
        default: begin emp = '0; full = 1'b0; end
      endcase
      start = pol == 1 && $urandom_range(0, 7) == 0;
      if (start) begin mode = 3'($urandom_range(0, 7)); dcfg = W'($urandom_range(0, 9)); pcfg = W'($urandom_range(0, 9)); end
      tick();
    end
    start = 1'b0; emp = '0; full = 1'b0;
    tick();
    tick();
    chk("op_beats", dut_beats, exp_beats);
  endtask

  initial begin
    int m, d, p;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", 32'({bus.busy, bus.pipe_enable, bus.out_fifo_wr_en, bus.process_cmpl, bus.cfg_err,
        bus.convMap_rd_en, bus.partMap_rd_en, bus.resdMap_rd_en, bus.prevMap_rd_en, bus.dwc_rd_en,
        bus.vector_add_pm, bus.vector_add_rm0, bus.vector_add_rm1, bus.vector_add_rm_conv, bus.vector_add_pv}), 32'(0));
    mon_en = 1;
    run_op(0, 3, 1, 0, 8);
    run_op(2, 2, 0, 3, 3);
    run_op(4, 15, 0, 2, 16);
    run_op(6, 1, 1, 0, 0);
    run_op(3, 0, 0, 0, 1);
    // abort after 4 of 8 beats, then a clean rerun
    mode = 3'd0; dcfg = 16'd3; pcfg = 16'd1; start = 1'b1; dut_beats = 0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    emp = 5'b11111; rdy_n = 1'b1;
    tick();
    rdy_n = 1'b0; emp = '0;
    tick(); tick();
    chk("abort_beats", dut_beats, 4);
    run_op(0, 3, 1, 0, 8);
    // reset mid-run, start accepted in the first cycle after reset
    mode = 3'd1; dcfg = 16'd4; pcfg = 16'd2; start = 1'b1; dut_beats = 0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    emp = 5'b11111; rst = 1'b1;
    tick();
    rst = 1'b0; emp = '0;
    chk("rst_abort_beats", dut_beats, 3);
    run_op(1, 1, 1, 0, 4);
    for (int i = 0; i < 25; i++) begin
      m = $urandom_range(0, 5); d = $urandom_range(0, 5); p = $urandom_range(0, 3);
      run_op(m, d, p, 1, m < 5 ? (d + 1) * (p + 1) : 0);
    end
    chk("beat_q_drained", beat_q.size(), 0);
    chk("cmpl_q_drained", cmpl_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
